sequencer: RTL
==============

# sequencer

Parametrised multi-cycle instruction sequencer for the mos6502 core; it is the successor to the two-state fetch/execute control unit. It walks each opcode through fetch, decode, operand-fetch and data-access cycles, with the cycle count set by the addressing-mode field of the instruction. It also honours a memory-ready stall and a halt opcode. It sits between the instruction register and the memory/PC datapath and drives the existing il/mm/mw control types.

## Interface
- DATA_W, 8: width of inst (data_t width).
- HALT_OPCODE, 8'h02: opcode that parks the sequencer in HALT until reset.
- STORE_AAA, 3'b100: inst[7:5] value that makes the data cycle a write.

- clk  in  1  system clock, all state changes on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- rdy  in  1  memory ready; low stalls the sequencer in its current state.
- inst  in  DATA_W  instruction register contents, valid from DECODE onward.
- il  out  il_t  LOAD in FETCH (IR captures memory data at cycle end), else NOLOAD.
- mm  out  mm_t  PC_ADDR in FETCH/OPER_LO/OPER_HI, A_ADDR in DATA, PC_ADDR otherwise.
- mw  out  mw_t  WRITE only in DATA when inst[7:5]==STORE_AAA, else READ.
- pc_inc  out  1  PC increment strobe: high in FETCH, OPER_LO, OPER_HI when rdy=1.
- sync  out  1  high in FETCH (opcode-fetch marker).
- halted  out  1  high in HALT.

## Operation
- States (local enum): FETCH, DECODE, OPER_LO, OPER_HI, DATA, HALT. State register is reset asynchronously to FETCH. Outputs are Moore decodes of the registered state; the only exception is that rdy gates pc_inc and il.
- Addressing mode is taken from bbb = inst[4:2] in DECODE:
  - 010 immediate: DECODE→OPER_LO→FETCH.
  - 001 zero page: DECODE→OPER_LO→DATA→FETCH.
  - 011 absolute: DECODE→OPER_LO→OPER_HI→DATA→FETCH.
  - any other value is implied: DECODE→FETCH.
- FETCH→DECODE unconditionally when rdy=1.
- In DECODE, inst==HALT_OPCODE → HALT; this takes priority over the bbb decode.
- HALT is absorbing: only reset exits it. In HALT, il=NOLOAD, mw=READ, pc_inc=0, sync=0.
- Stall: rdy=0 in any state holds the state and keeps mm/mw/sync at the values for that state, but forces il=NOLOAD and pc_inc=0. Exit from the state happens on the first edge with rdy=1.
- A store in DATA keeps mw=WRITE for every stalled cycle.
- Step counter step[2:0] counts cycles since FETCH. It is internal and exposed only for the bench through hierarchy. It resets to 0 in FETCH, increments on each non-stalled edge, and saturates at 7.
- Reset asserted mid-instruction (including mid-write): the state and all outputs take FETCH values immediately and asynchronously. No partial write is extended past reset assertion.

## Timing
- Reset values: state=FETCH, il=LOAD, mm=PC_ADDR, mw=READ, pc_inc=1 (when rdy=1), sync=1, halted=0.
- Cycles per instruction with rdy held high: implied 2, immediate 3, zero page 4, absolute 5. Each stalled cycle adds exactly 1.
- inst is sampled only in DECODE. Changes to inst during other states are ignored.
- Reset deassertion is synchronous to clk in use. The first rising edge after deassertion performs FETCH→DECODE if rdy=1.
- No combinational path from inst to any output. rdy→il/pc_inc is the only combinational input-to-output path.

## Test plan
- Reset then rdy=1, inst=8'hEA (bbb=010 → immediate): sync pulses every 3 cycles, pc_inc high in cycles 0 and 2, mm=PC_ADDR throughout.
- inst=8'h85 (aaa=100, bbb=001): 4-cycle sequence FETCH, DECODE, OPER_LO, DATA; in DATA mm=A_ADDR and mw=WRITE for exactly 1 cycle.
- inst=8'hAD (bbb=011): 5 cycles; pc_inc high in FETCH, OPER_LO, OPER_HI (3 pulses); mw stays READ.
- Same 8'h85 with rdy=0 for 3 cycles in DATA: mw=WRITE held for 4 cycles, pc_inc=0 and il=NOLOAD while stalled, total 7 cycles.
- inst=8'h02: after DECODE, halted=1 permanently across 20 cycles with rdy toggling; assert reset → halted=0, sync=1 before the next clk edge.
- Reset asserted between clock edges during OPER_HI of 8'hAD: outputs switch to FETCH values asynchronously; after release the next instruction runs in the full 5 cycles.

Source files
------------

// File: rtl/sequencer.sv
// Multi-cycle fetch/decode/operand/data sequencer for the mos6502 core.
// Outputs are registered decodes of the next state; rdy gates only il and pc_inc.
module sequencer #(
    parameter int                DATA_W      = 8,
    parameter logic [DATA_W-1:0] HALT_OPCODE = 8'h02,
    parameter logic [2:0]        STORE_AAA   = 3'b100
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rdy,
    input  logic [DATA_W-1:0] inst,
    output logic              il,
    output logic              mm,
    output logic              mw,
    output logic              pc_inc,
    output logic              sync,
    output logic              halted
);

    localparam logic IL_LOAD    = 1'b1;
    localparam logic IL_NOLOAD  = 1'b0;
    localparam logic MM_PC_ADDR = 1'b0;
    localparam logic MM_A_ADDR  = 1'b1;
    localparam logic MW_READ    = 1'b0;
    localparam logic MW_WRITE   = 1'b1;

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_OPER_LO, S_OPER_HI, S_DATA, S_HALT
    } state_t;

    typedef enum logic [1:0] {
        M_IMPL, M_IMM, M_ZP, M_ABS
    } mode_t;

    state_t     state_q, state_d;
    mode_t      mode_q, mode_d;
    logic       store_q, store_d;
    logic [2:0] step_q, step_d;
    logic       il_q, pc_inc_q, mm_q, mw_q, sync_q, halted_q;

    // Addressing mode and store flag are latched in DECODE so later cycles ignore inst.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        store_d = store_q;
        step_d  = step_q;
        if (rdy) begin
            case (state_q)
                S_FETCH:  state_d = S_DECODE;
                S_DECODE: begin
                    store_d = (inst[7:5] == STORE_AAA);
                    if (inst == HALT_OPCODE) begin
                        state_d = S_HALT;
                    end else begin
                        case (inst[4:2])
                            3'b010:  begin mode_d = M_IMM;  state_d = S_OPER_LO; end
                            3'b001:  begin mode_d = M_ZP;   state_d = S_OPER_LO; end
                            3'b011:  begin mode_d = M_ABS;  state_d = S_OPER_LO; end
                            default: begin mode_d = M_IMPL; state_d = S_FETCH;   end
                        endcase
                    end
                end
                S_OPER_LO: begin
                    case (mode_q)
                        M_ZP:    state_d = S_DATA;
                        M_ABS:   state_d = S_OPER_HI;
                        default: state_d = S_FETCH;
                    endcase
                end
                S_OPER_HI: state_d = S_DATA;
                S_DATA:    state_d = S_FETCH;
                S_HALT:    state_d = S_HALT;
                default:   state_d = S_FETCH;
            endcase
            if (state_d == S_FETCH)
                step_d = 3'd0;
            else if (step_q != 3'd7)
                step_d = step_q + 3'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_FETCH;
            mode_q   <= M_IMPL;
            store_q  <= 1'b0;
            step_q   <= 3'd0;
            il_q     <= IL_LOAD;
            pc_inc_q <= 1'b1;
            mm_q     <= MM_PC_ADDR;
            mw_q     <= MW_READ;
            sync_q   <= 1'b1;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            store_q  <= store_d;
            step_q   <= step_d;
            il_q     <= (state_d == S_FETCH) ? IL_LOAD : IL_NOLOAD;
            pc_inc_q <= (state_d == S_FETCH) || (state_d == S_OPER_LO) || (state_d == S_OPER_HI);
            mm_q     <= (state_d == S_DATA) ? MM_A_ADDR : MM_PC_ADDR;
            mw_q     <= ((state_d == S_DATA) && store_d) ? MW_WRITE : MW_READ;
            sync_q   <= (state_d == S_FETCH);
            halted_q <= (state_d == S_HALT);
        end
    end

    assign il     = il_q & rdy;
    assign pc_inc = pc_inc_q & rdy;
    assign mm     = mm_q;
    assign mw     = mw_q;
    assign sync   = sync_q;
    assign halted = halted_q;

endmodule
